// File: rtl/banked_memory_ctrl.sv
// Banked AGC main memory: request/response controller with bank switching, fixed-memory write protect,
// register-file aliasing of low addresses and editing locations. Accept->rspValid in 2 edges, 1 request per 3 cycles.
module banked_memory_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int PHYS_W    = 16,
    parameter int NUM_REGS  = 8,
    parameter int EDIT_BASE = 16
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [2:0]                 eBank,
    input  logic [4:0]                 fBank,
    input  logic                       superBank,
    input  logic [ADDR_W-1:0]          memAddress,
    input  logic [DATA_W-1:0]          dataIn,
    input  logic                       reqValid,
    input  logic                       reqWrite,
    output logic                       reqReady,
    input  logic [NUM_REGS*DATA_W-1:0] regIn,
    output logic                       regWrEn,
    output logic [$clog2(NUM_REGS)-1:0] regWrIdx,
    output logic [DATA_W-1:0]          regWrData,
    output logic                       rspValid,
    output logic [DATA_W-1:0]          rspData,
    output logic                       writeFault,
    output logic [PHYS_W-1:0]          finalAddress
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_write;
    logic [PHYS_W-1:0] r_phys;
    logic              r_rsp_vld;
    logic [DATA_W-1:0] r_rsp_dat;
    logic              r_wr_fault;
    logic              r_reg_wr_en;
    logic [IDX_W-1:0]  r_reg_wr_idx;
    logic [DATA_W-1:0] r_reg_wr_dat;
    logic [DATA_W-1:0] r_mem [0:(1<<PHYS_W)-1];

    logic [5:0]        w_fbank;
    logic [5:0]        w_fsel;
    logic [PHYS_W-1:0] w_phys;
    logic              w_is_reg;
    logic              w_is_edit;
    logic              w_is_fixed;
    logic [1:0]        w_edit_sel;
    logic [DATA_W-1:0] w_wr_dat;
    logic [DATA_W-1:0] w_rd_dat;
    logic [DATA_W-1:0] w_reg_rd;
    logic              w_do_write;

    // Address translation uses the live bank inputs, which are exactly the values latched on accept.
    always_comb begin
        w_fbank = {1'b0, fBank};
        if (superBank && fBank[4:3] == 2'b11)
            w_fbank = w_fbank + 6'd8;
        w_fsel = w_fbank;
        if (memAddress >= 12'h800)
            w_fsel = (memAddress < 12'hC00) ? 6'd2 : 6'd3;
        if (memAddress < 12'h300)
            w_phys = PHYS_W'(memAddress);
        else if (memAddress < 12'h400)
            w_phys = PHYS_W'({eBank, memAddress[7:0]});
        else
            w_phys = PHYS_W'(32'h800 + 32'(w_fsel) * 32'h400 + 32'(memAddress[9:0]));
    end

    assign w_is_reg   = r_addr < ADDR_W'(NUM_REGS);
    assign w_is_edit  = (r_addr >= ADDR_W'(EDIT_BASE)) && (r_addr <= ADDR_W'(EDIT_BASE + 3));
    assign w_edit_sel = 2'(r_addr - ADDR_W'(EDIT_BASE));
    assign w_is_fixed = r_phys >= PHYS_W'(32'h800);
    assign w_rd_dat   = r_mem[r_phys];
    assign w_reg_rd   = regIn[r_addr[IDX_W-1:0]*DATA_W +: DATA_W];
    assign w_do_write = (r_state == S_ACCESS) && r_write && !w_is_reg && !w_is_fixed;

    always_comb begin
        w_wr_dat = r_data;
        if (w_is_edit) begin
            case (w_edit_sel)
                2'd0:    w_wr_dat = {r_data[0], r_data[DATA_W-1:1]};
                2'd1:    w_wr_dat = {r_data[DATA_W-1], r_data[DATA_W-1:1]};
                2'd2:    w_wr_dat = {r_data[DATA_W-2:0], r_data[DATA_W-1]};
                default: w_wr_dat = DATA_W'(r_data[13:7]);
            endcase
        end
    end

    // Array has no reset; an async reset during ACCESS drops r_state before the edge, so no write lands.
    always_ff @(posedge clk) begin
        if (w_do_write)
            r_mem[r_phys] <= w_wr_dat;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_phys       <= '0;
            r_rsp_vld    <= 1'b0;
            r_rsp_dat    <= '0;
            r_wr_fault   <= 1'b0;
            r_reg_wr_en  <= 1'b0;
            r_reg_wr_idx <= '0;
            r_reg_wr_dat <= '0;
        end else begin
            r_rsp_vld   <= 1'b0;
            r_wr_fault  <= 1'b0;
            r_reg_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (reqValid) begin
                        r_addr  <= memAddress;
                        r_data  <= dataIn;
                        r_write <= reqWrite;
                        r_phys  <= w_phys;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state   <= S_RESP;
                    r_rsp_vld <= 1'b1;
                    if (r_write) begin
                        r_rsp_dat <= '0;
                        if (w_is_reg) begin
                            r_reg_wr_en  <= 1'b1;
                            r_reg_wr_idx <= r_addr[IDX_W-1:0];
                            r_reg_wr_dat <= r_data;
                        end else if (w_is_fixed) begin
                            r_wr_fault <= 1'b1;
                        end
                    end else begin
                        r_rsp_dat <= w_is_reg ? w_reg_rd : w_rd_dat;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reqReady     = (r_state == S_IDLE);
    assign rspValid     = r_rsp_vld;
    assign rspData      = r_rsp_dat;
    assign writeFault   = r_wr_fault;
    assign regWrEn      = r_reg_wr_en;
    assign regWrIdx     = r_reg_wr_idx;
    assign regWrData    = r_reg_wr_dat;
    assign finalAddress = r_phys;
endmodule
